pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have clk_in, input, 1, single clock, all state updates on posedge.
REQ-002 SHALL have rst_in, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have rdy_in, input, 1, global ready; low freezes all state.
REQ-004 SHALL have if_stall_req / id_stall_req / ex_stall_req / mem_stall_req, input, 1 each, stage stall requests.
REQ-005 SHALL have jump_enable, input, 1, EX taken branch/jump this cycle; jump_pc, input, 32, its target.
REQ-006 SHALL have if_busy, input, 1, instruction fetch outstanding; if_done, input, 1, fetch completes this cycle.
REQ-007 SHALL have stall_out, output, 6 (StallBus), bit k = stage k stalled (0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB).
REQ-008 SHALL have if_discard, output, 1, registered; drop the returning fetch.
REQ-009 SHALL have redirect_valid, output, 1, registered; redirect_pc, output, 32, registered; PC load command.
REQ-010 SHALL have stall_cnt_out, output, 32, stalled-cycle count (see Configuration).

Function
REQ-011 stall_out SHALL be combinational: request from stage s sets bits 0..s; the highest requesting stage wins; bit 5 always 0.
REQ-012 Pipeline register between stages X and X+1 holds when stall_out[X+1]=1 and inserts a bubble when stall_out[X]=1 and stall_out[X+1]=0; stall_out SHALL follow this encoding exactly.
REQ-013 FSM states SHALL be IDLE, WAIT_FETCH, REDIRECT.
REQ-014 IDLE: jump_enable=1 with if_busy=1 and if_done=0 -> WAIT_FETCH; jump_enable=1 otherwise -> REDIRECT; jump_pc latched into redirect_pc in both cases.
REQ-015 WAIT_FETCH: if_discard=1, stall_out[0] forced 1; if_done=1 -> REDIRECT; jump_enable=1 re-latches redirect_pc, stays unless if_done.
REQ-016 REDIRECT: redirect_valid=1 for exactly one cycle, then IDLE; jump_enable=1 in REDIRECT re-latches redirect_pc and stays REDIRECT one more cycle.
REQ-017 if_done coinciding with jump_enable in IDLE SHALL go directly to REDIRECT (the fetched word is killed by the EX flush).
REQ-018 Latency: jump_enable at cycle N -> redirect_valid at N+1 when no fetch pending, else one cycle after if_done.
REQ-019 rdy_in=0 SHALL hold state, redirect_pc, if_discard, redirect_valid and counter unchanged; stall_out still combinational.
REQ-020 if_discard and redirect_valid SHALL be decoded from registered state only, never mutually active.

Reset
REQ-021 rst_in=1 at posedge SHALL force IDLE, if_discard=0, redirect_valid=0, redirect_pc=0, stall_cnt_out=0, overriding rdy_in.
REQ-022 Reset in WAIT_FETCH or REDIRECT SHALL abandon the pending redirect with no redirect_valid pulse.

Configuration
REQ-023 Macro STALL_PERF_CNT_EN defined: stall_cnt_out increments by 1 each cycle with rdy_in=1 and stall_out[0]=1, wrapping 0xFFFFFFFF -> 0.
REQ-024 Macro STALL_PERF_CNT_EN undefined: no counter register; stall_cnt_out constant 0.

Verification
REQ-025 mem_stall_req=1 only -> stall_out=6'b011111; id_stall_req=1 only -> 6'b000111; none -> 6'b000000.
REQ-026 jump_enable=1, jump_pc=0x00001000, if_busy=0 at cycle N -> redirect_valid=1, redirect_pc=0x00001000 at N+1 only, IDLE at N+2.
REQ-027 jump at N with if_busy=1, if_done at N+3 -> if_discard=1 cycles N+1..N+3, stall_out[0]=1 same cycles, redirect_valid at N+4.
REQ-028 Second jump_pc=0x00002000 during WAIT_FETCH -> eventual redirect_pc=0x00002000; rst_in during WAIT_FETCH -> no redirect_valid, all outputs 0.
REQ-029 rdy_in=0 for 5 cycles mid-WAIT_FETCH -> state and outputs frozen, redirect after if_done with rdy_in=1.
REQ-030 With STALL_PERF_CNT_EN, counter preset-path: 10 stalled cycles -> stall_cnt_out=10; without macro -> 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall encoder and branch-redirect sequencer for a 6-stage in-order core.
// Optional stalled-cycle counter is built only when STALL_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_stall_req,
  input  logic              id_stall_req,
  input  logic              ex_stall_req,
  input  logic              mem_stall_req,
  input  logic              jump_enable,
  input  logic [DATA_W-1:0] jump_pc,
  input  logic              if_busy,
  input  logic              if_done,
  output logic [5:0]        stall_out,
  output logic              if_discard,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [31:0]       stall_cnt_out
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FETCH,
    REDIRECT
  } state_t;

  state_t state, state_nxt;

  // The highest requesting stage stalls itself and everything upstream;
  // WB never stalls. A pending fetch kill also holds the PC.
  always_comb begin
    stall_out = 6'b000000;
    if (mem_stall_req)     stall_out = 6'b011111;
    else if (ex_stall_req) stall_out = 6'b001111;
    else if (id_stall_req) stall_out = 6'b000111;
    else if (if_stall_req) stall_out = 6'b000011;
    if (state == WAIT_FETCH) stall_out[0] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (jump_enable) begin
          if (if_busy && !if_done) state_nxt = WAIT_FETCH;
          else                     state_nxt = REDIRECT;
        end
      end
      WAIT_FETCH: begin
        if (if_done) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        // A younger taken branch in EX supersedes the target being issued.
        state_nxt = jump_enable ? REDIRECT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      redirect_pc <= '0;
    end else if (rdy_in) begin
      state <= state_nxt;
      if (jump_enable) redirect_pc <= jump_pc;
    end
  end

  // Outputs decode straight from the state register, so they are glitch-free
  // and can never be active together.
  assign if_discard     = (state == WAIT_FETCH);
  assign redirect_valid = (state == REDIRECT);

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt <= 32'd0;
    end else if (rdy_in && stall_out[0]) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_out = stall_cnt;
`else
  assign stall_cnt_out = 32'd0;
`endif

endmodule
